// File: rtl/sw_stripe_ctrl.sv
// sw_stripe_ctrl: sequencer for a NUM_PE-wide systolic Smith-Waterman array.
// It first buffers SEQ_LEN S/T symbol pairs. It then sweeps the S sequence in
// stripes of NUM_PE symbols. For each stripe it loads the S chunk, streams all
// of T, drains the array, and folds the array running max into the global best.
// The last-PE H column goes to an external boundary RAM so the next stripe can
// read it back.
//
// Ports
//   clk, reset            : clock, asynchronous active-low reset
//   valid, data_s, data_t : input symbol strobe and S/T symbols
//   pe_load, pe_s_data    : S chunk load into the PEs (PE0 in the LSBs)
//   pe_clear              : clear PE H / running-max registers
//   pe_t_valid, pe_t_data : T symbol stream into PE0
//   pe_bnd_zero           : force PE0 left boundary to 0 (stripe 0)
//   bnd_rd_en/addr        : boundary RAM read (1-cycle latency RAM)
//   bnd_wr_en/addr        : boundary RAM write of the last-PE H column
//   pe_max                : array running max, stable from the end of DRAIN
//   busy, finish, max     : activity flag, done pulse, global best score
module sw_stripe_ctrl #(
  parameter int unsigned SEQ_LEN = 256,
  parameter int unsigned NUM_PE  = 16,
  parameter int unsigned SCORE_W = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid,
  input  logic [1:0]                 data_s,
  input  logic [1:0]                 data_t,
  output logic                       pe_load,
  output logic [2*NUM_PE-1:0]        pe_s_data,
  output logic                       pe_clear,
  output logic                       pe_t_valid,
  output logic [1:0]                 pe_t_data,
  output logic                       pe_bnd_zero,
  output logic                       bnd_rd_en,
  output logic [$clog2(SEQ_LEN)-1:0] bnd_rd_addr,
  output logic                       bnd_wr_en,
  output logic [$clog2(SEQ_LEN)-1:0] bnd_wr_addr,
  input  logic [SCORE_W-1:0]         pe_max,
  output logic                       busy,
  output logic                       finish,
  output logic [SCORE_W-1:0]         max
);

  localparam int unsigned AW         = $clog2(SEQ_LEN);
  localparam int unsigned NUM_STRIPE = SEQ_LEN / NUM_PE;
  localparam int unsigned KW         = (NUM_STRIPE > 1) ? $clog2(NUM_STRIPE) : 1;
  localparam logic [AW-1:0] LAST_IDX   = AW'(SEQ_LEN - 1);
  localparam logic [AW-1:0] LAST_DRAIN = AW'(NUM_PE - 1);
  localparam logic [KW-1:0] LAST_K     = KW'(NUM_STRIPE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_INIT, S_STREAM, S_DRAIN, S_UPDATE, S_DONE
  } state_t;

  state_t              state_q, state_n;
  logic [KW-1:0]       k_q, k_n;
  logic [AW-1:0]       cnt_q, cnt_n;
  logic [SCORE_W-1:0]  max_q, max_n;

  logic                pe_load_n, pe_clear_n, pe_t_valid_n, pe_bnd_zero_n;
  logic [2*NUM_PE-1:0] pe_s_data_n;
  logic [1:0]          pe_t_data_n;
  logic                bnd_rd_en_n;
  logic [AW-1:0]       bnd_rd_addr_n;
  logic                busy_n, finish_n;
  logic [AW-1:0]       chunk_base;

  logic [1:0]          s_buf [SEQ_LEN];
  logic [1:0]          t_buf [SEQ_LEN];
  logic                buf_we;

  logic [NUM_PE-1:0]   dl_v;
  logic [AW-1:0]       dl_a [NUM_PE];
  logic                dl_in_v;
  logic [AW-1:0]       dl_in_a;

  // Symbol buffers; cnt_q is 0 in IDLE so the first symbol lands at index 0.
  assign buf_we = valid && ((state_q == S_IDLE) || (state_q == S_LOAD));

  always_ff @(posedge clk) begin
    if (buf_we) begin
      s_buf[cnt_q] <= data_s;
      t_buf[cnt_q] <= data_t;
    end
  end

  // Next-state, counters and the registered-output images of the next cycle.
  always_comb begin
    state_n       = state_q;
    k_n           = k_q;
    cnt_n         = cnt_q;
    max_n         = max_q;
    pe_load_n     = 1'b0;
    pe_clear_n    = 1'b0;
    pe_s_data_n   = '0;
    pe_t_valid_n  = 1'b0;
    pe_t_data_n   = '0;
    pe_bnd_zero_n = 1'b0;
    bnd_rd_en_n   = 1'b0;
    bnd_rd_addr_n = '0;
    busy_n        = 1'b0;
    finish_n      = 1'b0;
    chunk_base    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          state_n = S_LOAD;
          cnt_n   = AW'(1);
          max_n   = '0;
        end
      end
      S_LOAD: begin
        if (valid) begin
          if (cnt_q == LAST_IDX) begin
            state_n = S_INIT;
            cnt_n   = '0;
            k_n     = '0;
          end else begin
            cnt_n = cnt_q + AW'(1);
          end
        end
      end
      S_INIT: begin
        state_n = S_STREAM;
        cnt_n   = '0;
      end
      S_STREAM: begin
        if (cnt_q == LAST_IDX) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == LAST_DRAIN) begin
          state_n = S_UPDATE;
          cnt_n   = '0;
          // Commit the stripe max on UPDATE entry so it is visible during UPDATE.
          if (pe_max > max_q) max_n = pe_max;
        end else begin
          cnt_n = cnt_q + AW'(1);
        end
      end
      S_UPDATE: begin
        if (k_q == LAST_K) begin
          state_n = S_DONE;
        end else begin
          k_n     = k_q + KW'(1);
          state_n = S_INIT;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        k_n     = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        k_n     = '0;
      end
    endcase

    busy_n   = (state_n != S_IDLE);
    finish_n = (state_n == S_DONE);

    if (state_n == S_INIT) begin
      pe_load_n  = 1'b1;
      pe_clear_n = 1'b1;
      chunk_base = AW'(32'(k_n) * NUM_PE);
      for (int i = 0; i < int'(NUM_PE); i++) begin
        pe_s_data_n[2*i +: 2] = s_buf[chunk_base + AW'(i)];
      end
    end

    if (state_n == S_STREAM) begin
      pe_t_valid_n = 1'b1;
      pe_t_data_n  = t_buf[cnt_n];
    end

    pe_bnd_zero_n = (k_n == '0) &&
                    (state_n inside {S_INIT, S_STREAM, S_DRAIN, S_UPDATE});

    // Boundary reads run one cycle ahead of the T strobe for the same j.
    if (k_n != '0) begin
      if (state_n == S_INIT) begin
        bnd_rd_en_n   = 1'b1;
        bnd_rd_addr_n = '0;
      end else if ((state_n == S_STREAM) && (cnt_n != LAST_IDX)) begin
        bnd_rd_en_n   = 1'b1;
        bnd_rd_addr_n = cnt_n + AW'(1);
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      max_q       <= '0;
      pe_load     <= 1'b0;
      pe_clear    <= 1'b0;
      pe_s_data   <= '0;
      pe_t_valid  <= 1'b0;
      pe_t_data   <= '0;
      pe_bnd_zero <= 1'b0;
      bnd_rd_en   <= 1'b0;
      bnd_rd_addr <= '0;
      busy        <= 1'b0;
      finish      <= 1'b0;
    end else begin
      state_q     <= state_n;
      k_q         <= k_n;
      cnt_q       <= cnt_n;
      max_q       <= max_n;
      pe_load     <= pe_load_n;
      pe_clear    <= pe_clear_n;
      pe_s_data   <= pe_s_data_n;
      pe_t_valid  <= pe_t_valid_n;
      pe_t_data   <= pe_t_data_n;
      pe_bnd_zero <= pe_bnd_zero_n;
      bnd_rd_en   <= bnd_rd_en_n;
      bnd_rd_addr <= bnd_rd_addr_n;
      busy        <= busy_n;
      finish      <= finish_n;
    end
  end

  assign max = max_q;

  // Write-tag delay line matching the array latency. While in STREAM, cnt_q
  // is the j currently on pe_t_valid. The last stripe has no consumer.
  assign dl_in_v = (state_q == S_STREAM) && (k_q != LAST_K);
  assign dl_in_a = dl_in_v ? cnt_q : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dl_v <= '0;
      for (int i = 0; i < int'(NUM_PE); i++) dl_a[i] <= '0;
    end else begin
      dl_v    <= {dl_v[NUM_PE-2:0], dl_in_v};
      dl_a[0] <= dl_in_a;
      for (int i = 1; i < int'(NUM_PE); i++) dl_a[i] <= dl_a[i-1];
    end
  end

  assign bnd_wr_en   = dl_v[NUM_PE-1];
  assign bnd_wr_addr = dl_a[NUM_PE-1];

endmodule

// File: doc/sw_stripe_ctrl.md
SW_STRIPE_CTRL -- requirements
Module: sw_stripe_ctrl

Interface
REQ-001 Parameter SEQ_LEN, 256, symbols per sequence (S and T); a multiple of NUM_PE.
REQ-002 Parameter NUM_PE, 16, PEs in the external systolic array; equals the array pipeline latency in cycles.
REQ-003 Parameter SCORE_W, 12, score width.
REQ-004 clk  in  1  single clock; all flops update on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 valid  in  1  input symbol strobe.
REQ-007 data_s  in  2  S symbol; data_t  in  2  T symbol.
REQ-008 pe_load  out  1  load S chunk into the PEs; pe_s_data  out  2*NUM_PE  S chunk, with PE0 in the LSBs.
REQ-009 pe_clear  out  1  clear PE H/running-max registers.
REQ-010 pe_t_valid  out  1  T symbol strobe into PE0; pe_t_data  out  2  T symbol.
REQ-011 pe_bnd_zero  out  1  PE0 left boundary forced to 0 (stripe 0).
REQ-012 bnd_rd_en  out  1  and bnd_rd_addr  out  log2(SEQ_LEN)  boundary RAM read (synchronous RAM, 1-cycle latency).
REQ-013 bnd_wr_en  out  1  and bnd_wr_addr  out  log2(SEQ_LEN)  boundary RAM write of the last-PE H column.
REQ-014 pe_max  in  SCORE_W  array running max, stable from the end of DRAIN.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 finish  out  1  1-cycle done pulse; max  out  SCORE_W  global best score.

Function
REQ-017 States: IDLE, LOAD, INIT, STREAM, DRAIN, UPDATE and DONE; one-hot or binary encoding is acceptable.
REQ-018 IDLE->LOAD on valid=1; that symbol is stored at index 0; max clears to 0 on this transition.
REQ-019 LOAD: each valid=1 cycle stores data_s/data_t into internal SEQ_LEN x 2 S/T buffers at the next index; valid=0 gaps hold the index.
REQ-020 The edge that samples symbol SEQ_LEN-1 moves LOAD->INIT; stripe counter k=0.
REQ-021 valid is ignored outside IDLE/LOAD.
REQ-022 INIT (1 cycle): pe_load=1, pe_clear=1, pe_s_data=S[k*NUM_PE .. k*NUM_PE+NUM_PE-1].
REQ-023 STREAM (SEQ_LEN cycles, j=0..SEQ_LEN-1): pe_t_valid=1, pe_t_data=T[j].
REQ-024 pe_bnd_zero=1 throughout stripe k=0 and 0 for k>0.
REQ-025 For k>0, bnd_rd_en=1 with bnd_rd_addr=j one cycle before pe_t_valid for j; this includes the INIT cycle for j=0, and no read is issued in the last STREAM cycle.
REQ-026 bnd_wr_en=1 with bnd_wr_addr=j exactly NUM_PE cycles after pe_t_valid for j, in every stripe except the last; the j tags come from a NUM_PE-deep delay line.
REQ-027 Read address j of stripe k+1 never precedes write address j of stripe k.
REQ-028 DRAIN: NUM_PE cycles with pe_t_valid=0; the boundary writes complete here.
REQ-029 UPDATE (1 cycle): if pe_max > max (unsigned), then max <= pe_max.
REQ-030 UPDATE exit: k == SEQ_LEN/NUM_PE-1 goes to DONE; otherwise k<=k+1 and go to INIT.
REQ-031 Stripe period: 1+SEQ_LEN+NUM_PE+1 = 274 cycles at defaults.
REQ-032 DONE (1 cycle): finish=1, then go to IDLE.
REQ-033 max holds until the next IDLE->LOAD transition.
REQ-034 All PE/RAM strobes are 0 whenever they are not explicitly asserted above.
REQ-035 Default latency: finish is high in the cycle after the 4384th rising edge following the edge that sampled symbol 255.

Reset
REQ-036 reset=0 asynchronously forces IDLE, all counters 0, all outputs 0 (max=0, finish=0, busy=0), from any state including mid-STREAM.
REQ-037 S/T buffer contents need no reset.
REQ-038 After reset is released, a new load starts from index 0; no partial state survives.

Verification
REQ-039 Reset: assert reset=0 mid-STREAM of stripe 3 -> all outputs 0 in the same cycle; after release, valid=1 starts a fresh LOAD and finish follows per REQ-035.
REQ-040 Back-to-back load of 256 symbols, with a scoreboard counting edges -> 16 INIT pulses 274 cycles apart; finish at edge 4384; busy=1 from the first sample to finish.
REQ-041 Load with valid gaps (valid=0 on cycles 10-12 and 100) -> buffers hold the exact sequence in order; INIT follows the 256th valid sample.
REQ-042 Per-stripe pe_max driven as 5, 9, 3, 9, 7, then 0 for the rest -> max=9 at finish; max equals 9 in all of UPDATE stripes 1-15 and DONE.
REQ-043 Boundary trace -> stripe 0: no bnd_rd_en and pe_bnd_zero=1; stripes 0-14: 256 writes with addresses 0..255, each NUM_PE cycles after its T strobe; stripes 1-15: 256 reads with addresses 0..255, each 1 cycle ahead of its T strobe; stripe 15: no writes.
REQ-044 A valid=1 pulse during STREAM/DRAIN -> no effect on state, buffers or outputs; pe_s_data in stripe k=2 equals S[32..47].
